// File: rtl/mfe_led7seg_74hc595_receiver.sv
// -----------------------------------------------------------------------------
// mfe_led7seg_74hc595_receiver
//
// Receive end of the 74HC595 serial LED display interface. The transmitter
// drives three wires (sclk, rclk, dio) that are asynchronous to clk_i. Each wire
// is brought into the clk_i domain through a SYNC_STAGES-deep flop chain.
// Rising edges are then detected on the synchronised signals.
//
// Every sclk rising edge shifts one dio bit into a shift register, MSB of the
// word first, and counts it. An rclk rising edge latches the assembled word.
// The word is published on a valid/ready port only if exactly DAT_WIDTH bits
// were shifted since the previous latch. Any other count produces a one-cycle
// len_err pulse and the word is dropped.
//
// The block serves as an on-FPGA display sniffer/emulator and as the checker
// for the 595 display controller in loopback benches.
//
// Parameters:
//   DIG_NUM      number of digit-select bits (upper field of the word)
//   SEG_NUM      number of segment bits (lower field of the word)
//   SYNC_STAGES  synchroniser depth on sclk/rclk/dio, legal range 2..4
//   DAT_WIDTH    (local) DIG_NUM + SEG_NUM
//
// Ports:
//   clk_i      system clock, the only clock
//   rst_ni     asynchronous active-low reset
//   sclk_i     serial shift clock from the transmitter (async to clk_i)
//   rclk_i     storage/latch clock from the transmitter (async to clk_i)
//   dio_i      serial data, MSB first
//   dat_o      received word: digits in the upper DIG_NUM bits,
//              segments in the lower SEG_NUM bits
//   vld_o      dat_o valid
//   rdy_i      downstream accept
//   len_err_o  one-cycle pulse: latch seen with a bit count other than DAT_WIDTH
//   ovf_o      one-cycle pulse: pending word overwritten before acceptance
//   seg_map_o  (optional) rebuilt multiplexed display image, SEG_NUM bits
//              per digit slot
//
// Optional feature macro: MFE_LED7SEG_RX_DIGIT_MAP_EN
//   When defined, this adds seg_map_o. On every accepted word, each set digit
//   bit i copies the segment field into slot i. When undefined, the port and
//   its registers are absent.
// -----------------------------------------------------------------------------
module mfe_led7seg_74hc595_receiver #(
  parameter int DIG_NUM     = 8,
  parameter int SEG_NUM     = 8,
  parameter int SYNC_STAGES = 2,
  localparam int DAT_WIDTH  = DIG_NUM + SEG_NUM
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 sclk_i,
  input  logic                 rclk_i,
  input  logic                 dio_i,
  output logic [DAT_WIDTH-1:0] dat_o,
  output logic                 vld_o,
  input  logic                 rdy_i,
  output logic                 len_err_o,
  output logic                 ovf_o
`ifdef MFE_LED7SEG_RX_DIGIT_MAP_EN
  ,
  output logic [DIG_NUM*SEG_NUM-1:0] seg_map_o
`endif
);

  // The counter must be able to hold DAT_WIDTH+1. That value marks an
  // over-long frame, so a saturated count can never match DAT_WIDTH.
  localparam int CNT_W = $clog2(DAT_WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DAT_WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DAT_WIDTH + 1);

  // ---------------------------------------------------------------------------
  // Synchronisers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclkSync_q, sclkSync_d;
  logic [SYNC_STAGES-1:0] rclkSync_q, rclkSync_d;
  logic [SYNC_STAGES-1:0] dioSync_q,  dioSync_d;

  // History flops hold the previous value of the last synchroniser stage.
  logic sclkHist_q, sclkHist_d;
  logic rclkHist_q, rclkHist_d;

  // The edge pulses are registered so that the shift/latch logic works from a
  // flop rather than from a compare on the synchroniser output. dioDly_q
  // delays the data by the same single stage. It therefore holds the dio
  // value seen in the same cycle that the synchronised sclk was first high.
  logic sclkRise_q, sclkRise_d;
  logic rclkRise_q, rclkRise_d;
  logic dioDly_q,   dioDly_d;

  always_comb begin
    sclkSync_d = {sclkSync_q[SYNC_STAGES-2:0], sclk_i};
    rclkSync_d = {rclkSync_q[SYNC_STAGES-2:0], rclk_i};
    dioSync_d  = {dioSync_q[SYNC_STAGES-2:0],  dio_i};
    sclkHist_d = sclkSync_q[SYNC_STAGES-1];
    rclkHist_d = rclkSync_q[SYNC_STAGES-1];
    sclkRise_d = sclkSync_q[SYNC_STAGES-1] & ~sclkHist_q;
    rclkRise_d = rclkSync_q[SYNC_STAGES-1] & ~rclkHist_q;
    dioDly_d   = dioSync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclkSync_q <= '0;
      rclkSync_q <= '0;
      dioSync_q  <= '0;
      sclkHist_q <= 1'b0;
      rclkHist_q <= 1'b0;
      sclkRise_q <= 1'b0;
      rclkRise_q <= 1'b0;
      dioDly_q   <= 1'b0;
    end else begin
      sclkSync_q <= sclkSync_d;
      rclkSync_q <= rclkSync_d;
      dioSync_q  <= dioSync_d;
      sclkHist_q <= sclkHist_d;
      rclkHist_q <= rclkHist_d;
      sclkRise_q <= sclkRise_d;
      rclkRise_q <= rclkRise_d;
      dioDly_q   <= dioDly_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Shift register and bit counter
  // ---------------------------------------------------------------------------
  logic [DAT_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;

  // The shift register is not cleared on a latch. Only the counter restarts.
  // When sclk and rclk rise together, the latch sees the pre-shift count.
  // The freshly shifted bit is then the first bit of the next frame, so the
  // counter restarts at 1.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (sclkRise_q) begin
      shreg_d = {shreg_q[DAT_WIDTH-2:0], dioDly_q};
    end
    if (rclkRise_q) begin
      cnt_d = sclkRise_q ? CNT_W'(1) : '0;
    end else if (sclkRise_q && (cnt_q != CNT_SAT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Latch, handshake and error pulses
  // ---------------------------------------------------------------------------
  logic [DAT_WIDTH-1:0] dat_q, dat_d;
  logic                 vld_q, vld_d;
  logic                 lenErr_q, lenErr_d;
  logic                 ovf_q, ovf_d;
  logic                 goodLatch;
  logic                 accept;

  assign goodLatch = rclkRise_q && (cnt_q == CNT_FULL);
  assign accept    = vld_q & rdy_i;

  // A good latch always wins over an accept in the same cycle. The new word is
  // presented with vld held high. An overwrite is flagged only if the pending
  // word was not being taken in that same cycle.
  always_comb begin
    dat_d    = dat_q;
    vld_d    = vld_q;
    lenErr_d = rclkRise_q && (cnt_q != CNT_FULL);
    ovf_d    = 1'b0;
    if (goodLatch) begin
      dat_d = shreg_q;
      vld_d = 1'b1;
      ovf_d = vld_q & ~rdy_i;
    end else if (accept) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dat_q    <= '0;
      vld_q    <= 1'b0;
      lenErr_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      dat_q    <= dat_d;
      vld_q    <= vld_d;
      lenErr_q <= lenErr_d;
      ovf_q    <= ovf_d;
    end
  end

  assign dat_o     = dat_q;
  assign vld_o     = vld_q;
  assign len_err_o = lenErr_q;
  assign ovf_o     = ovf_q;

`ifdef MFE_LED7SEG_RX_DIGIT_MAP_EN
  // ---------------------------------------------------------------------------
  // Display image rebuild
  // ---------------------------------------------------------------------------
  logic [DIG_NUM*SEG_NUM-1:0] segMap_q, segMap_d;

  // Each accepted word updates every slot whose digit-select bit is set.
  // Several digits may share one segment pattern. A word with no digit bits
  // set leaves the image untouched.
  always_comb begin
    segMap_d = segMap_q;
    if (accept) begin
      for (int i = 0; i < DIG_NUM; i++) begin
        if (dat_q[SEG_NUM + i]) begin
          segMap_d[i*SEG_NUM +: SEG_NUM] = dat_q[SEG_NUM-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      segMap_q <= '0;
    end else begin
      segMap_q <= segMap_d;
    end
  end

  assign seg_map_o = segMap_q;
`endif

endmodule
